// File: rtl/dcm_lock_qualifier.sv
// dcm_lock_qualifier
//   Conditions the raw LOCKED outputs of two DCMs into clean, debounced lock
//   flags for the downstream DCM arbiter. It also issues per-DCM reset pulses
//   to re-acquire a DCM that does not lock within a timeout. The two channels
//   are identical, independent and share the single clock domain clk_i.
//
//   Optional feature macro: LOCK_STATUS_EN
//     defined   : per-channel lock-loss counters (loss_cnt_f*_o) and their
//                 synchronous clear input (cnt_clr_i) are present.
//     undefined : no counters; those ports and the CntW parameter are absent.
//
// Ports
//   clk_i            system clock
//   rst_i            asynchronous reset, active-high
//   locked_raw_f1_i  DCM1 LOCKED, asynchronous to clk_i
//   locked_raw_f2_i  DCM2 LOCKED, asynchronous to clk_i
//   cnt_clr_i        clears both loss counters (LOCK_STATUS_EN only)
//   loss_cnt_f1_o    saturating lock-loss count, DCM1 (LOCK_STATUS_EN only)
//   loss_cnt_f2_o    saturating lock-loss count, DCM2 (LOCK_STATUS_EN only)
//   locked_f1_o      qualified lock, DCM1
//   locked_f2_o      qualified lock, DCM2
//   dcm_rst_f1_o     reset request to DCM1, active-high
//   dcm_rst_f2_o     reset request to DCM2, active-high
module dcm_lock_qualifier #(
    parameter int unsigned QualCycles    = 1024,
    parameter int unsigned TimeoutCycles = 65536,
    parameter int unsigned RstCycles     = 8,
    parameter int unsigned TmrW          = 17
`ifdef LOCK_STATUS_EN
    ,
    parameter int unsigned CntW          = 8
`endif
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            locked_raw_f1_i,
    input  logic            locked_raw_f2_i,
`ifdef LOCK_STATUS_EN
    input  logic            cnt_clr_i,
    output logic [CntW-1:0] loss_cnt_f1_o,
    output logic [CntW-1:0] loss_cnt_f2_o,
`endif
    output logic            locked_f1_o,
    output logic            locked_f2_o,
    output logic            dcm_rst_f1_o,
    output logic            dcm_rst_f2_o
);

    typedef enum logic [1:0] {
        StRstDcm,
        StWaitLock,
        StQualify,
        StLocked
    } state_e;

    // Terminal timer values: a state is left on the edge where the timer holds
    // its last value, so each phase lasts exactly the parameterised cycle count.
    localparam logic [TmrW-1:0] RstLast  = TmrW'(RstCycles - 1);
    localparam logic [TmrW-1:0] ToLast   = TmrW'(TimeoutCycles - 1);
    localparam logic [TmrW-1:0] QualLast = TmrW'(QualCycles - 1);
    localparam logic [TmrW-1:0] TmrMax   = {TmrW{1'b1}};

    logic [1:0] raw;
    logic [1:0] locked;
    logic [1:0] dcm_rst;

    assign raw = {locked_raw_f2_i, locked_raw_f1_i};

`ifdef LOCK_STATUS_EN
    logic [CntW-1:0] loss_cnt [2];
`endif

    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic [1:0]      sync_q;
        logic            sync;
        state_e          state_q, state_d;
        logic [TmrW-1:0] timer_q, timer_d;
        logic [TmrW-1:0] timer_inc;
        logic            locked_q;
        logic            dcm_rst_c;

        // sync_q[0] is the metastability-catching stage.
        assign sync      = sync_q[1];
        assign timer_inc = (timer_q == TmrMax) ? timer_q : timer_q + TmrW'(1);

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                sync_q   <= 2'b00;
                state_q  <= StRstDcm;
                timer_q  <= '0;
                locked_q <= 1'b0;
            end else begin
                sync_q   <= {sync_q[0], raw[c]};
                state_q  <= state_d;
                timer_q  <= timer_d;
                locked_q <= (state_d == StLocked);
            end
        end

        always_comb begin
            state_d = state_q;
            timer_d = timer_q;
            unique case (state_q)
                StRstDcm: begin
                    if (timer_q == RstLast) begin
                        state_d = StWaitLock;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_inc;
                    end
                end
                StWaitLock: begin
                    // A lock indication beats a coincident timeout.
                    if (sync) begin
                        state_d = StQualify;
                        timer_d = '0;
                    end else if (timer_q == ToLast) begin
                        state_d = StRstDcm;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_inc;
                    end
                end
                StQualify: begin
                    if (!sync) begin
                        state_d = StWaitLock;
                        timer_d = '0;
                    end else if (timer_q == QualLast) begin
                        state_d = StLocked;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_inc;
                    end
                end
                StLocked: begin
                    timer_d = '0;
                    // Loss is not answered with a DCM reset; the wait timeout covers it.
                    if (!sync) begin
                        state_d = StWaitLock;
                    end
                end
                default: begin
                    state_d = StRstDcm;
                    timer_d = '0;
                end
            endcase
        end

        always_comb begin
            dcm_rst_c = (state_q == StRstDcm);
        end

        assign locked[c]  = locked_q;
        assign dcm_rst[c] = dcm_rst_c;

`ifdef LOCK_STATUS_EN
        logic [CntW-1:0] loss_q, loss_d;
        logic            lost;

        assign lost = (state_q == StLocked) && (state_d == StWaitLock);

        always_comb begin
            loss_d = loss_q;
            if (cnt_clr_i) begin
                loss_d = '0;
            end else if (lost && (loss_q != {CntW{1'b1}})) begin
                loss_d = loss_q + CntW'(1);
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                loss_q <= '0;
            end else begin
                loss_q <= loss_d;
            end
        end

        assign loss_cnt[c] = loss_q;
`endif
    end

    assign locked_f1_o  = locked[0];
    assign locked_f2_o  = locked[1];
    assign dcm_rst_f1_o = dcm_rst[0];
    assign dcm_rst_f2_o = dcm_rst[1];

`ifdef LOCK_STATUS_EN
    assign loss_cnt_f1_o = loss_cnt[0];
    assign loss_cnt_f2_o = loss_cnt[1];
`endif

endmodule

// File: tb/tb_dcm_lock_qualifier.sv
// Bench for dcm_lock_qualifier with QualCycles=16, TimeoutCycles=100,
// RstCycles=4 (and CntW=4 when LOCK_STATUS_EN is defined). A timestamp-based
// reference model predicts every output each cycle; directed scenarios add
// fixed-latency checks. Cycle k is the interval after the k-th clock edge
// following reset release (cycle 0 directly follows release).
module tb_dcm_lock_qualifier;

    localparam int Qual    = 16;
    localparam int Timeout = 100;
    localparam int RstLen  = 4;
    localparam int CntMax  = 15;

    localparam int PhRst  = 0;
    localparam int PhWait = 1;
    localparam int PhQual = 2;
    localparam int PhLock = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic raw1 = 1'b0;
    logic raw2 = 1'b0;
    logic cnt_clr = 1'b0;
    logic locked1, locked2, dcm_rst1, dcm_rst2;
`ifdef LOCK_STATUS_EN
    logic [3:0] loss1, loss2;
`endif

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;
    int cyc = 0;

    always #5 clk = ~clk;

    dcm_lock_qualifier #(
        .QualCycles    (Qual),
        .TimeoutCycles (Timeout),
        .RstCycles     (RstLen),
        .TmrW          (8)
`ifdef LOCK_STATUS_EN
        ,
        .CntW          (4)
`endif
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .locked_raw_f1_i (raw1),
        .locked_raw_f2_i (raw2),
`ifdef LOCK_STATUS_EN
        .cnt_clr_i       (cnt_clr),
        .loss_cnt_f1_o   (loss1),
        .loss_cnt_f2_o   (loss2),
`endif
        .locked_f1_o     (locked1),
        .locked_f2_o     (locked2),
        .dcm_rst_f1_o    (dcm_rst1),
        .dcm_rst_f2_o    (dcm_rst2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, $signed(got),
                     $signed(exp));
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Reference model: each channel remembers its phase and the edge number at
    // which it entered that phase; the synchronised input is the raw value two
    // edges old.
    int m_ph   [2] = '{PhRst, PhRst};
    int m_ent  [2] = '{0, 0};
    int m_cnt  [2] = '{0, 0};
    bit m_dly1 [2] = '{1'b0, 1'b0};
    bit m_dly2 [2] = '{1'b0, 1'b0};
    int m_edge = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_edge = 0;
            for (int c = 0; c < 2; c++) begin
                m_ph[c] = PhRst; m_ent[c] = 0; m_cnt[c] = 0;
                m_dly1[c] = 1'b0; m_dly2[c] = 1'b0;
            end
        end else begin
            m_edge++;
            for (int c = 0; c < 2; c++) begin
                bit seen;
                bit lost;
                seen = m_dly2[c];
                m_dly2[c] = m_dly1[c];
                m_dly1[c] = (c == 0) ? raw1 : raw2;
                lost = 1'b0;
                case (m_ph[c])
                    PhRst:  if (m_edge - m_ent[c] == RstLen) begin
                                m_ph[c] = PhWait; m_ent[c] = m_edge;
                            end
                    PhWait: if (seen) begin
                                m_ph[c] = PhQual; m_ent[c] = m_edge;
                            end else if (m_edge - m_ent[c] == Timeout) begin
                                m_ph[c] = PhRst; m_ent[c] = m_edge;
                            end
                    PhQual: if (!seen) begin
                                m_ph[c] = PhWait; m_ent[c] = m_edge;
                            end else if (m_edge - m_ent[c] == Qual) begin
                                m_ph[c] = PhLock; m_ent[c] = m_edge;
                            end
                    default: if (!seen) begin
                                m_ph[c] = PhWait; m_ent[c] = m_edge; lost = 1'b1;
                            end
                endcase
                if (cnt_clr)   m_cnt[c] = 0;
                else if (lost) m_cnt[c] = (m_cnt[c] < CntMax) ? m_cnt[c] + 1 : CntMax;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check_eq("locked_f1", 32'(locked1), 32'(m_ph[0] == PhLock));
            check_eq("locked_f2", 32'(locked2), 32'(m_ph[1] == PhLock));
            check_eq("dcm_rst_f1", 32'(dcm_rst1), 32'(m_ph[0] == PhRst));
            check_eq("dcm_rst_f2", 32'(dcm_rst2), 32'(m_ph[1] == PhRst));
`ifdef LOCK_STATUS_EN
            check_eq("loss_cnt_f1", 32'(loss1), 32'(m_cnt[0]));
            check_eq("loss_cnt_f2", 32'(loss2), 32'(m_cnt[1]));
`endif
        end
    end

    // Event monitor for the directed latency checks.
    int first_lock1, first_lock2, first_rise2, n_rise2, n_hi1, last_hi1;
    bit prev_dr2;
    always @(negedge clk) begin
        if (rst) begin
            first_lock1 = -1; first_lock2 = -1; first_rise2 = -1;
            n_rise2 = 0; n_hi1 = 0; last_hi1 = -1; prev_dr2 = 1'b1;
        end else begin
            if (first_lock1 < 0 && locked1) first_lock1 = cyc;
            if (first_lock2 < 0 && locked2) first_lock2 = cyc;
            if (dcm_rst2 && !prev_dr2) begin
                n_rise2++;
                if (first_rise2 < 0) first_rise2 = cyc;
            end
            prev_dr2 = dcm_rst2;
            if (cyc <= 9 && dcm_rst1) begin
                n_hi1++; last_hi1 = cyc;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic goto_cycle(input int k);
        while (cyc < k) tick(1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        #1 chk_en = 1'b1;
        tick(3);
        check_eq("reset_locked_f1", 32'(locked1), 32'd0);
        check_eq("reset_dcm_rst_f1", 32'(dcm_rst1), 32'd1);
        rst = 1'b0;

        // Scenario: f1 rises at cycle 10, f2 stays low across two timeouts.
        goto_cycle(10);
        raw1 = 1'b1;
        goto_cycle(220);
        check_eq("s1_dcm_rst_f1_width", 32'(n_hi1), 32'd4);
        check_eq("s1_dcm_rst_f1_last", 32'(last_hi1), 32'd3);
        check_eq("s1_lock_f1_cycle", 32'(first_lock1), 32'd29);
        check_eq("s2_rerst_f2_first", 32'(first_rise2), 32'd104);
        check_eq("s2_rerst_f2_count", 32'(n_rise2), 32'd2);
        check_eq("s2_never_lock_f2", 32'(first_lock2), 32'hffff_ffff);

        // Scenario: one-cycle glitch in f1 qualification, then loss on f2.
        raw1 = 1'b0; raw2 = 1'b0;
        do_reset();
        goto_cycle(10);
        raw1 = 1'b1; raw2 = 1'b1;
        goto_cycle(21);
        raw1 = 1'b0;
        goto_cycle(22);
        raw1 = 1'b1;
        goto_cycle(60);
        check_eq("s3_lock_f1_cycle", 32'(first_lock1), 32'd41);
        check_eq("s4_lock_f2_cycle", 32'(first_lock2), 32'd29);
        raw2 = 1'b0;
        goto_cycle(62);
        check_eq("s4_f2_still_locked", 32'(locked2), 32'd1);
        goto_cycle(63);
        check_eq("s4_f2_dropped", 32'(locked2), 32'd0);
        check_eq("s4_f1_unaffected", 32'(locked1), 32'd1);
`ifdef LOCK_STATUS_EN
        check_eq("s4_loss_f2", 32'(loss2), 32'd1);
        check_eq("s4_loss_f1", 32'(loss1), 32'd0);
`endif

        // Scenario: async reset while f1 qualifies and f2 is locked.
        raw1 = 1'b0; raw2 = 1'b1;
        do_reset();
        goto_cycle(10);
        raw1 = 1'b1;
        goto_cycle(25);
        check_eq("s6_f2_locked_before", 32'(locked2), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("s6_async_locked_f2", 32'(locked2), 32'd0);
        check_eq("s6_async_dcm_rst_f1", 32'(dcm_rst1), 32'd1);
        check_eq("s6_async_dcm_rst_f2", 32'(dcm_rst2), 32'd1);
        #1;
        do_reset();
        goto_cycle(40);
        check_eq("s6_relock_f1_cycle", 32'(first_lock1), 32'd21);
        check_eq("s6_relock_f2_cycle", 32'(first_lock2), 32'd21);

`ifdef LOCK_STATUS_EN
        // Scenario: counter saturation, then clear racing an increment.
        raw1 = 1'b0; raw2 = 1'b1;
        do_reset();
        goto_cycle(30);
        for (int i = 0; i < 20; i++) begin
            raw2 = 1'b0;
            tick(5);
            raw2 = 1'b1;
            tick(25);
        end
        check_eq("s5_loss_saturated", 32'(loss2), 32'd15);
        check_eq("s5_locked_before_clr", 32'(locked2), 32'd1);
        raw2 = 1'b0;
        tick(2);
        cnt_clr = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
        check_eq("s5_clr_wins", 32'(loss2), 32'd0);
        check_eq("s5_lost_on_clr_edge", 32'(locked2), 32'd0);
`endif

        // Random traffic: variable high/low runs per channel, sparse clears and resets.
        begin
            int dur [2];
            raw1 = 1'b0; raw2 = 1'b0;
            dur[0] = 1; dur[1] = 1;
            do_reset();
            for (int i = 0; i < 4000; i++) begin
                for (int c = 0; c < 2; c++) begin
                    dur[c]--;
                    if (dur[c] <= 0) begin
                        bit nv;
                        nv = (c == 0) ? !raw1 : !raw2;
                        if (c == 0) raw1 = nv;
                        else        raw2 = nv;
                        dur[c] = nv ? int'($urandom_range(1, 45)) : int'($urandom_range(1, 130));
                    end
                end
                cnt_clr = ($urandom_range(0, 49) == 0);
                if ($urandom_range(0, 1499) == 0) do_reset();
                else                             tick(1);
            end
            cnt_clr = 1'b0;
        end

        tick(2);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
